// File: rtl/enemy_bullet_ctrl.sv
// Enemy projectile engine: picks a pseudo-random living alien column, spawns a
// bullet under its lowest alien, drops it once per frame and reports paddle hits.
// Also produces the registered per-pixel draw strobe and colour for the mixer.
module enemy_bullet_ctrl #(
  parameter int          HRES               = 1280,
  parameter int          VRES               = 720,
  parameter int          NUM_COLS           = 10,
  parameter int          SPACING_X          = 50,
  parameter int          ENEMY_W            = 32,
  parameter int          BULLET_W           = 4,
  parameter int          BULLET_H           = 16,
  parameter int          EBULLET_SPEED      = 8,
  parameter int          PADDLE_W           = 50,
  parameter int          PADDLE_H           = 20,
  parameter int          COOLDOWN           = 48,
  parameter logic [23:0] ENEMY_BULLET_COLOR = 24'hFF0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                game_active,
  input  logic [NUM_COLS-1:0] alive_mask,
  input  logic [10:0]         grid_x,
  output logic [3:0]          fire_col,
  input  logic [9:0]          fire_col_y,
  input  logic [10:0]         paddle_x,
  input  logic [10:0]         hcount,
  input  logic [9:0]          vcount,
  output logic                bullet_active,
  output logic [10:0]         bullet_x,
  output logic [9:0]          bullet_y,
  output logic                player_hit,
  output logic                draw,
  output logic [23:0]         rgb
);

  localparam int CD_W = $clog2(COOLDOWN + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_FLY    = 2'd2;

  logic [1:0]      state_q,    state_d;
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic [15:0]     lfsr_q,     lfsr_d;
  logic [3:0]      cand_q,     cand_d;
  logic [3:0]      tries_q,    tries_d;
  logic [10:0]     bx_q,       bx_d;
  logic [9:0]      by_q,       by_d;
  logic            active_q,   active_d;
  logic            hit_q,      hit_d;
  logic            draw_q,     draw_d;

  logic [3:0]  first_cand;
  logic [11:0] spawn_x;
  logic [10:0] new_y;
  logic        hit_now;

  // Fibonacci LFSR (taps 16,14,13,11), shifted toward the MSB every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Datapath helpers: start column, spawn position, next y and paddle overlap.
  always_comb begin
    first_cand = (lfsr_q[3:0] >= 4'(NUM_COLS)) ? lfsr_q[3:0] - 4'(NUM_COLS) : lfsr_q[3:0];
    spawn_x    = {1'b0, grid_x} + 12'(cand_q) * 12'(SPACING_X)
               + 12'((ENEMY_W - BULLET_W) / 2);
    new_y      = {1'b0, by_q} + 11'(EBULLET_SPEED);
    hit_now    = ({1'b0, new_y} + 12'(BULLET_H) >= 12'(VRES - PADDLE_H))
              && (new_y < 11'(VRES))
              && ({1'b0, bx_q} < {1'b0, paddle_x} + 12'(PADDLE_W))
              && ({1'b0, bx_q} + 12'(BULLET_W) > {1'b0, paddle_x});
  end

  // Control FSM: cooldown, column search, flight and termination.
  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    cand_d     = cand_q;
    tries_d    = tries_q;
    bx_d       = bx_q;
    by_d       = by_q;
    active_d   = active_q;
    hit_d      = 1'b0;
    if (!game_active) begin
      state_d    = S_IDLE;
      active_d   = 1'b0;
      cooldown_d = CD_W'(COOLDOWN);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_tick) begin
            if (cooldown_q != '0) begin
              cooldown_d = cooldown_q - 1'b1;
            end else begin
              state_d = S_SELECT;
              cand_d  = first_cand;
              tries_d = '0;
            end
          end
        end
        S_SELECT: begin
          if (alive_mask[cand_q]) begin
            bx_d     = spawn_x[10:0];
            by_d     = fire_col_y;
            active_d = 1'b1;
            state_d  = S_FLY;
          end else if (tries_q == 4'(NUM_COLS - 1)) begin
            state_d    = S_IDLE;
            cooldown_d = CD_W'(COOLDOWN);
          end else begin
            tries_d = tries_q + 1'b1;
            cand_d  = (cand_q == 4'(NUM_COLS - 1)) ? '0 : cand_q + 1'b1;
          end
        end
        S_FLY: begin
          if (frame_tick) begin
            // Hit takes priority over leaving the screen on the same frame.
            if (hit_now) begin
              hit_d      = 1'b1;
              active_d   = 1'b0;
              state_d    = S_IDLE;
              cooldown_d = CD_W'(COOLDOWN);
            end else if (new_y >= 11'(VRES)) begin
              active_d   = 1'b0;
              state_d    = S_IDLE;
              cooldown_d = CD_W'(COOLDOWN);
            end else begin
              by_d = new_y[9:0];
            end
          end
        end
        default: begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end
      endcase
    end
  end

  // Pixel coverage test against the current bullet rectangle.
  always_comb begin
    draw_d = active_q
          && ({1'b0, hcount} >= {1'b0, bx_q})
          && ({1'b0, hcount} <  {1'b0, bx_q} + 12'(BULLET_W))
          && ({1'b0, vcount} >= {1'b0, by_q})
          && ({1'b0, vcount} <  {1'b0, by_q} + 11'(BULLET_H));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cooldown_q <= CD_W'(COOLDOWN);
      lfsr_q     <= 16'hACE1;
      cand_q     <= '0;
      tries_q    <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      active_q   <= 1'b0;
      hit_q      <= 1'b0;
      draw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cooldown_q <= cooldown_d;
      lfsr_q     <= lfsr_d;
      cand_q     <= cand_d;
      tries_q    <= tries_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      active_q   <= active_d;
      hit_q      <= hit_d;
      draw_q     <= draw_d;
    end
  end

  // Output mapping; the column query is only live while searching.
  always_comb begin
    fire_col      = (state_q == S_SELECT) ? cand_q : '0;
    bullet_active = active_q;
    bullet_x      = bx_q;
    bullet_y      = by_q;
    player_hit    = hit_q;
    draw          = draw_q;
    rgb           = draw_q ? ENEMY_BULLET_COLOR : '0;
  end

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Bench for enemy_bullet_ctrl: cycle-by-cycle comparison against a behavioural
// model, directed scenarios for spawn/hit/miss/abort/reset, a pixel table,
// and a randomized soak.
module tb_enemy_bullet_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        game_active;
  logic [9:0]  alive_mask;
  logic [10:0] grid_x;
  logic [3:0]  fire_col;
  logic [9:0]  fire_col_y;
  logic [10:0] paddle_x;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        bullet_active;
  logic [10:0] bullet_x;
  logic [9:0]  bullet_y;
  logic        player_hit;
  logic        draw;
  logic [23:0] rgb;

  int n_vec = 0;
  int n_err = 0;
  int hit_cnt = 0;

  // Reference model state (plain integers)
  int m_mode;   // 0 waiting, 1 searching, 2 in flight
  int m_cool, m_cand, m_tried, m_bx, m_by, m_act, m_hit, m_draw, m_lfsr;

  enemy_bullet_ctrl #(.NUM_COLS(10), .COOLDOWN(48)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_active(game_active),
    .alive_mask(alive_mask), .grid_x(grid_x), .fire_col(fire_col),
    .fire_col_y(fire_col_y), .paddle_x(paddle_x), .hcount(hcount), .vcount(vcount),
    .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .player_hit(player_hit), .draw(draw), .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hc;
    int vc;
    int exp_draw;
  } pix_vec_t;

  function automatic int lfsr_next(int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 'hFFFF;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cool = 48; m_lfsr = 'hACE1; m_cand = 0; m_tried = 0;
    m_bx = 0; m_by = 0; m_act = 0; m_hit = 0; m_draw = 0;
  endtask

  task automatic model_step();
    int old_l, nd, ny, hc, vc, px;
    old_l = m_lfsr;
    hc = int'(hcount); vc = int'(vcount); px = int'(paddle_x);
    nd = (m_act != 0 && hc >= m_bx && hc < m_bx + 4 && vc >= m_by && vc < m_by + 16) ? 1 : 0;
    m_lfsr = lfsr_next(m_lfsr);
    m_hit = 0;
    if (!game_active) begin
      m_mode = 0; m_act = 0; m_cool = 48;
    end else if (m_mode == 0) begin
      if (frame_tick) begin
        if (m_cool > 0) m_cool--;
        else begin
          m_mode = 1; m_cand = (old_l % 16) % 10; m_tried = 0;
        end
      end
    end else if (m_mode == 1) begin
      if (alive_mask[m_cand]) begin
        m_bx = (int'(grid_x) + m_cand * 50 + 14) % 2048;
        m_by = int'(fire_col_y);
        m_act = 1; m_mode = 2;
      end else begin
        m_tried++;
        if (m_tried == 10) begin
          m_mode = 0; m_cool = 48;
        end else m_cand = (m_cand + 1) % 10;
      end
    end else if (frame_tick) begin
      ny = m_by + 8;
      if (ny + 16 >= 700 && ny < 720 && m_bx < px + 50 && m_bx + 4 > px) begin
        m_hit = 1; m_act = 0; m_mode = 0; m_cool = 48;
      end else if (ny >= 720) begin
        m_act = 0; m_mode = 0; m_cool = 48;
      end else m_by = ny;
    end
    m_draw = nd;
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cyc_active", int'(bullet_active), m_act);
    chk("cyc_x", int'(bullet_x), m_bx);
    chk("cyc_y", int'(bullet_y), m_by);
    chk("cyc_hit", int'(player_hit), m_hit);
    chk("cyc_draw", int'(draw), m_draw);
    chk("cyc_rgb", int'(rgb), m_draw ? 'hFF0000 : 0);
    chk("cyc_fire_col", int'(fire_col), (m_mode == 1) ? m_cand : 0);
    if (player_hit) hit_cnt++;
  endtask

  task automatic frame(input int gap);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_active"}, int'(bullet_active), 0);
    chk({tag, "_x"}, int'(bullet_x), 0);
    chk({tag, "_y"}, int'(bullet_y), 0);
    chk({tag, "_hit"}, int'(player_hit), 0);
    chk({tag, "_draw"}, int'(draw), 0);
    chk({tag, "_rgb"}, int'(rgb), 0);
    chk({tag, "_fire_col"}, int'(fire_col), 0);
  endtask

  task automatic do_reset();
    frame_tick = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    hit_cnt = 0;
  endtask

  // Frames (12-cycle gap) until a bullet appears; returns the count.
  task automatic frames_to_fire(output int n);
    n = 0;
    for (int i = 0; i < 60 && !bullet_active; i++) begin
      frame(12);
      n++;
    end
  endtask

  task automatic frames_to_end(output int n);
    n = 0;
    for (int i = 0; i < 80 && bullet_active; i++) begin
      frame(4);
      n++;
    end
  endtask

  initial begin
    pix_vec_t pix[12];
    int n;

    pix[0]  = '{263, 300, 0}; pix[1]  = '{264, 300, 1};
    pix[2]  = '{267, 300, 1}; pix[3]  = '{268, 300, 0};
    pix[4]  = '{264, 299, 0}; pix[5]  = '{264, 315, 1};
    pix[6]  = '{264, 316, 0}; pix[7]  = '{267, 315, 1};
    pix[8]  = '{266, 308, 1}; pix[9]  = '{100, 100, 0};
    pix[10] = '{268, 316, 0}; pix[11] = '{263, 299, 0};

    rst_n = 1'b1; frame_tick = 1'b0; game_active = 1'b1;
    alive_mask = 10'h008; grid_x = 11'd100; fire_col_y = 10'd200;
    paddle_x = 11'd250; hcount = '0; vcount = '0;
    #2;

    // Spawn under column 3, fly into the paddle, then refire after cooldown
    do_reset();
    frames_to_fire(n);
    chk("fire_tick_count", n, 49);
    chk("spawn_x", int'(bullet_x), 264);
    chk("spawn_y", int'(bullet_y), 200);
    chk("spawn_active", int'(bullet_active), 1);
    frames_to_end(n);
    chk("hit_tick", n, 61);
    chk("hit_pulses", hit_cnt, 1);
    frames_to_fire(n);
    chk("refire_tick_count", n, 49);

    // Paddle out of the way: falls off the bottom
    paddle_x = 11'd600;
    do_reset();
    frames_to_fire(n);
    frames_to_end(n);
    chk("miss_tick", n, 65);
    chk("miss_no_hit", hit_cnt, 0);

    // Empty grid: search covers exactly ten columns then gives up
    alive_mask = '0;
    do_reset();
    repeat (48) frame(12);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (10) tick();
    alive_mask = '1;
    repeat (5) tick();
    chk("empty_no_fire", int'(bullet_active), 0);
    frames_to_fire(n);
    chk("empty_cooldown_reload", n, 49);

    // Game stops on the very frame that would have hit
    alive_mask = 10'h008; paddle_x = 11'd250;
    do_reset();
    frames_to_fire(n);
    repeat (60) frame(4);
    game_active = 1'b0;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("abort_active", int'(bullet_active), 0);
    chk("abort_no_hit", hit_cnt, 0);
    repeat (3) tick();
    game_active = 1'b1;

    // Asynchronous reset in flight clears outputs without a clock edge
    do_reset();
    frames_to_fire(n);
    repeat (5) frame(4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Pixel table around a bullet parked at (264,300)
    fire_col_y = 10'd300;
    do_reset();
    frames_to_fire(n);
    chk("park_x", int'(bullet_x), 264);
    chk("park_y", int'(bullet_y), 300);
    foreach (pix[i]) begin
      hcount = 11'(pix[i].hc);
      vcount = 10'(pix[i].vc);
      tick();
      chk("pix_draw", int'(draw), pix[i].exp_draw);
      chk("pix_rgb", int'(rgb), pix[i].exp_draw ? 'hFF0000 : 0);
    end

    // Randomized soak against the model
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      frame_tick  = ($urandom_range(0, 2) == 0);
      game_active = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 150) == 0)
        alive_mask = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 60) == 0) grid_x = 11'($urandom_range(0, 1200));
      fire_col_y = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 30) == 0) paddle_x = 11'(m_bx - int'($urandom_range(0, 60)) + 5);
      hcount = 11'(m_bx + int'($urandom_range(0, 7)) - 2);
      vcount = 10'(m_by + int'($urandom_range(0, 20)) - 2);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enemy_bullet_ctrl.md
Name: enemy_bullet_ctrl

Overview:
- Enemy-side projectile engine: the downward-travelling counterpart of the player bullet.
- Picks a pseudo-random living alien column, spawns a bullet under that column's bottom alien, moves it down once per frame, and flags a hit on the player paddle.
- Sits beside the enemy grid block and the paddle block; feeds the pixel mux with a draw strobe and colour.

Parameters:
- HRES, 1280, screen width in pixels.
- VRES, 720, screen height in pixels.
- NUM_COLS, 10, alien columns.
- SPACING_X, 50, column pitch in pixels.
- ENEMY_W, 32, alien width.
- BULLET_W, 4, bullet width.
- BULLET_H, 16, bullet height.
- EBULLET_SPEED, 8, pixels moved per frame.
- PADDLE_W, 50, paddle width.
- PADDLE_H, 20, paddle height.
- COOLDOWN, 48, frames between a bullet ending and the next firing attempt.
- ENEMY_BULLET_COLOR, 24'hFF0000, bullet colour.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- game_active  in  1  gameplay running; low forces idle
- alive_mask  in  NUM_COLS  bit c=1 when column c has at least one living alien
- grid_x  in  11  x of the alien grid's left edge
- fire_col  out  4  column being queried; combinational lookup into the enemy block
- fire_col_y  in  10  y of the bottom edge of the lowest living alien in fire_col, valid the same cycle
- paddle_x  in  11  paddle left x
- hcount  in  11  current pixel x
- vcount  in  10  current pixel y
- bullet_active  out  1  bullet in flight
- bullet_x  out  11  bullet left x
- bullet_y  out  10  bullet top y
- player_hit  out  1  one-cycle pulse on paddle hit
- draw  out  1  current pixel is bullet
- rgb  out  24  ENEMY_BULLET_COLOR when draw, else 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cooldown=COOLDOWN, lfsr=16'hACE1.
  - All outputs 0: bullet_active, bullet_x, bullet_y, player_hit, draw, rgb, fire_col.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk cycle when not in reset.
- game_active=0 in any state, including mid-flight:
  - next cycle state=IDLE, bullet_active=0, cooldown=COOLDOWN.
  - No player_hit is generated.
- IDLE:
  - On frame_tick with cooldown>0: cooldown decrements.
  - On frame_tick with cooldown==0: go to SELECT and load cand = lfsr[3:0], minus NUM_COLS if cand >= NUM_COLS.
- SELECT (at most NUM_COLS cycles, one column per cycle):
  - fire_col=cand.
  - If alive_mask[cand]=1:
    - latch bullet_x = grid_x + cand*SPACING_X + (ENEMY_W-BULLET_W)/2; compute in 12 bits, truncate to 11.
    - latch bullet_y = fire_col_y.
    - set bullet_active=1 and go to FLY.
  - Otherwise cand = cand+1, wrapping NUM_COLS-1→0.
  - After NUM_COLS misses: go to IDLE with cooldown=COOLDOWN.
- FLY, on each frame_tick:
  - new_y = bullet_y + EBULLET_SPEED, computed in 11 bits.
  - Hit is checked before exit:
    - Hit condition: new_y+BULLET_H >= VRES-PADDLE_H, and new_y < VRES, and bullet_x < paddle_x+PADDLE_W, and bullet_x+BULLET_W > paddle_x.
    - On hit: player_hit=1 for exactly one cycle; bullet_active=0; go to IDLE with cooldown=COOLDOWN.
  - Else if new_y >= VRES (miss): bullet_active=0; go to IDLE with cooldown=COOLDOWN.
  - Else bullet_y=new_y.
  - No movement between frame_ticks.
- Pixel path, registered, 1-cycle latency from hcount/vcount:
  - draw = bullet_active and bullet_x <= hcount < bullet_x+BULLET_W and bullet_y <= vcount < bullet_y+BULLET_H.
  - rgb follows draw.
- Limits:
  - Only one enemy bullet exists at a time.
  - alive_mask changing during FLY does not affect the bullet in flight.

Test Plan:
- Reset, game_active=1, alive_mask=10'h008, grid_x=100, fire_col_y=200 → after 49 frame_ticks, SELECT lands on column 3 within ≤10 cycles; bullet_x=264, bullet_y=200, bullet_active=1.
- Same setup, paddle_x=250 → 61st FLY tick: new_y=688, player_hit pulses for 1 cycle, bullet_active=0; next attempt occurs after 48 further ticks.
- Same setup, paddle_x=600 → no hit; bullet_active drops on the 65th FLY tick (new_y=720); player_hit never asserts.
- alive_mask=0 → SELECT exits after exactly 10 cycles, back to IDLE with cooldown=48, bullet_active stays 0.
- Mid-flight game_active→0 → bullet_active=0 next cycle, no player_hit. Mid-flight rst_n→0 → all outputs 0 immediately (asynchronous).
- bullet at (264,300), sweep hcount/vcount → draw=1 with rgb=FF0000 exactly for x∈[264,268), y∈[300,316), one cycle after each coordinate is presented.
